// File: rtl/piezo_tune_sched.sv
// piezo_tune_sched: arbitrates alert requesters and issues one tune's notes over a vld/rdy + done handshake
// Optional feature macro: TUNE_SCHED_PREEMPT_EN (urgent FAST tune preempts STEER/BATT at a note boundary)
module piezo_tune_sched #(
  parameter logic        FAST_SIM   = 1'b1,
  parameter logic [27:0] REPEAT_CNT = 28'h8F0D180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        too_fast,
  input  logic        batt_low,
  input  logic        en_steer,
  input  logic        note_rdy,
  input  logic        note_done,
  output logic        note_vld,
  output logic [14:0] note_prd,
  output logic [24:0] note_dur,
  output logic [1:0]  tune_id,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, PLAY} state_t;
  localparam logic [1:0] NONE = 2'd0, STEER = 2'd1, BATT = 2'd2, FAST = 2'd3;
  localparam logic [14:0] G6 = 15'h7C90, C7 = 15'h5D51, E7 = 15'h4A11, G7 = 15'h3E48;
  localparam logic [27:0] STEP = FAST_SIM ? 28'd64 : 28'd1;
  state_t      state;
  logic [27:0] rpt_cntr;
  logic [2:0]  idx;
  logic        rpt;
  logic        last;
  logic        preempt;
  logic        go_on;
  logic [1:0]  start_tune;
  logic [1:0]  nxt_tune;
  logic [2:0]  nxt_idx;
  // BATT walks the STEER table backwards; FAST uses the first three STEER notes
  function automatic logic [39:0] note_of(input logic [1:0] t, input logic [2:0] i);
    logic [2:0] k;
    k = (t == BATT) ? 3'd5 - i : i;
    case (k)
      3'd0:    note_of = {G6, 25'h07FFFFF};
      3'd1:    note_of = {C7, 25'h07FFFFF};
      3'd2:    note_of = {E7, 25'h07FFFFF};
      3'd3:    note_of = {G7, 25'h0BFFFFF};
      3'd4:    note_of = {E7, 25'h03FFFFF};
      default: note_of = {G7, 25'h1FFFFFF};
    endcase
  endfunction
  assign rpt        = rpt_cntr >= REPEAT_CNT;
  assign busy       = state != IDLE;
  assign start_tune = too_fast ? FAST : (rpt && batt_low) ? BATT : (rpt && en_steer) ? STEER : NONE;
  assign last       = (tune_id == FAST) ? (idx == 3'd2) : (idx == 3'd5);
`ifdef TUNE_SCHED_PREEMPT_EN
  assign preempt    = too_fast && (tune_id == STEER || tune_id == BATT);
`else
  assign preempt    = 1'b0;
`endif
  assign go_on      = preempt || !last || (tune_id == FAST && too_fast);
  assign nxt_tune   = preempt ? FAST : tune_id;
  assign nxt_idx    = (preempt || last) ? 3'd0 : idx + 3'd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rpt_cntr <= '0;
      idx      <= '0;
      tune_id  <= NONE;
      note_vld <= 1'b0;
      note_prd <= '0;
      note_dur <= '0;
    end else begin
      rpt_cntr <= rpt ? 28'd0 : rpt_cntr + STEP;
      case (state)
        IDLE: if (start_tune != NONE) begin
          tune_id              <= start_tune;
          idx                  <= 3'd0;
          {note_prd, note_dur} <= note_of(start_tune, 3'd0);
          note_vld             <= 1'b1;
          state                <= ISSUE;
        end
        ISSUE: if (note_rdy) begin
          note_vld <= 1'b0;
          state    <= PLAY;
        end
        PLAY: if (note_done) begin
          if (go_on) begin
            tune_id              <= nxt_tune;
            idx                  <= nxt_idx;
            {note_prd, note_dur} <= note_of(nxt_tune, nxt_idx);
            note_vld             <= 1'b1;
            state                <= ISSUE;
          end else begin
            tune_id <= NONE;
            idx     <= 3'd0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
